// File: rtl/alarm_ctrl.sv
`timescale 1ns/1ps
// alarm_ctrl: central sequencer for the alarm clock.
// Owns the 1 Hz prescaler, time-of-day and alarm registers, and the
// set/ring/snooze state machine. Everything runs on Clk; the per-second
// work is qualified by the registered Tick enable.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined;
// without it the SNOOZE state does not exist and Inc while ringing is ignored.
module alarm_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Mode,
    input  logic       Inc,
    input  logic       Stop,
    input  logic       AlarmOn,
    output logic       Tick,
    output logic [4:0] DispHr,
    output logic [5:0] DispMin,
    output logic [5:0] Sec,
    output logic [2:0] State,
    output logic       Buzz
);

    localparam int PC_W   = $clog2(TICK_DIV);
    localparam int RT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int RT_W   = $clog2(RT_MAX + 1);

    localparam logic [PC_W-1:0] PC_LAST   = PC_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0] PC_PRE    = PC_W'(TICK_DIV - 2);
    localparam logic [RT_W-1:0] RING_LAST = RT_W'(RING_SEC - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [RT_W-1:0] SNZ_LAST  = RT_W'(SNOOZE_SEC - 1);
`endif

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_SET_HR  = 3'd1;
    localparam logic [2:0] S_SET_MIN = 3'd2;
    localparam logic [2:0] S_ALM_HR  = 3'd3;
    localparam logic [2:0] S_ALM_MIN = 3'd4;
    localparam logic [2:0] S_RING    = 3'd5;
`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] S_SNOOZE  = 3'd6;
`endif

    // prescaler
    logic [PC_W-1:0] r_pc;
    logic            r_tick;

    // time of day and alarm registers
    logic [4:0] r_hr, r_ahr;
    logic [5:0] r_min, r_sec, r_amin;

    // state machine
    logic [2:0]      r_state, w_state_nxt;
    logic [RT_W-1:0] r_rt, w_rt_nxt;
    logic            r_buzz, w_buzz_nxt;
    logic            r_aon_d;

    // resolved button pulses and helpers
    logic       w_mode, w_inc, w_aon_fall, w_trig, w_time_run;
    logic [5:0] w_sec_adv, w_min_adv, w_min_inc, w_amin_inc;
    logic [4:0] w_hr_adv, w_hr_inc, w_ahr_inc;

    // Stop beats Mode beats Inc; the losers are simply dropped.
    assign w_mode     = Mode & ~Stop;
    assign w_inc      = Inc & ~Stop & ~Mode;
    assign w_aon_fall = r_aon_d & ~AlarmOn;

    // modular increments of each field
    assign w_hr_inc   = (r_hr   == 5'd23) ? 5'd0 : r_hr   + 5'd1;
    assign w_min_inc  = (r_min  == 6'd59) ? 6'd0 : r_min  + 6'd1;
    assign w_ahr_inc  = (r_ahr  == 5'd23) ? 5'd0 : r_ahr  + 5'd1;
    assign w_amin_inc = (r_amin == 6'd59) ? 6'd0 : r_amin + 6'd1;

    // time one second ahead, with carries
    assign w_sec_adv = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
    assign w_min_adv = (r_sec == 6'd59) ? w_min_inc : r_min;
    assign w_hr_adv  = (r_sec == 6'd59 && r_min == 6'd59) ? w_hr_inc : r_hr;

    // clock keeps running everywhere except while the time itself is being set
    assign w_time_run = r_tick && (r_state != S_SET_HR) && (r_state != S_SET_MIN);

    // alarm fires on the tick that lands exactly on ahr:amin:00
    assign w_trig = (r_state == S_RUN) && AlarmOn && r_tick &&
                    (w_hr_adv == r_ahr) && (w_min_adv == r_amin) && (w_sec_adv == 6'd0);

    // prescaler: Tick is registered so it is high while pc sits at TICK_DIV-1
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pc   <= (r_pc == PC_LAST) ? '0 : r_pc + PC_W'(1);
            r_tick <= (r_pc == PC_PRE);
        end
    end

    // time-of-day and alarm field updates
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hr   <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_ahr  <= '0;
            r_amin <= '0;
        end else begin
            if (r_state == S_SET_HR && w_inc) begin
                r_hr <= w_hr_inc;
            end else if (r_state == S_SET_MIN && w_inc) begin
                // setting minutes restarts the second count
                r_min <= w_min_inc;
                r_sec <= 6'd0;
            end else if (w_time_run) begin
                r_sec <= w_sec_adv;
                r_min <= w_min_adv;
                r_hr  <= w_hr_adv;
            end
            // alarm fields edit independently of the running clock
            if (r_state == S_ALM_HR && w_inc)
                r_ahr <= w_ahr_inc;
            if (r_state == S_ALM_MIN && w_inc)
                r_amin <= w_amin_inc;
        end
    end

    // state register, ring timer and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_RUN;
            r_rt    <= '0;
            r_buzz  <= 1'b0;
            r_aon_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rt    <= w_rt_nxt;
            r_buzz  <= w_buzz_nxt;
            r_aon_d <= AlarmOn;
        end
    end

    // next-state and ring-timer logic
    always_comb begin
        w_state_nxt = r_state;
        w_rt_nxt    = r_rt;
        case (r_state)
            S_RUN: begin
                // an alarm hit outranks a Mode pulse in the same cycle so it is never lost
                if (w_trig) begin
                    w_state_nxt = S_RING;
                    w_rt_nxt    = '0;
                end else if (w_mode) begin
                    w_state_nxt = S_SET_HR;
                end
            end
            S_SET_HR:  if (w_mode) w_state_nxt = S_SET_MIN;
            S_SET_MIN: if (w_mode) w_state_nxt = S_ALM_HR;
            S_ALM_HR:  if (w_mode) w_state_nxt = S_ALM_MIN;
            S_ALM_MIN: if (w_mode) w_state_nxt = S_RUN;
            S_RING: begin
                // Mode doubles as Stop while the alarm is active
                if (Stop || Mode || w_aon_fall) begin
                    w_state_nxt = S_RUN;
                    w_rt_nxt    = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (w_inc) begin
                    w_state_nxt = S_SNOOZE;
                    w_rt_nxt    = '0;
`endif
                end else if (r_tick) begin
                    if (r_rt == RING_LAST) begin
                        w_state_nxt = S_RUN;
                        w_rt_nxt    = '0;
                    end else begin
                        w_rt_nxt = r_rt + RT_W'(1);
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (Stop || Mode) begin
                    w_state_nxt = S_RUN;
                    w_rt_nxt    = '0;
                end else if (r_tick) begin
                    if (r_rt == SNZ_LAST) begin
                        w_state_nxt = S_RING;
                        w_rt_nxt    = '0;
                    end else begin
                        w_rt_nxt = r_rt + RT_W'(1);
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_RUN;
                w_rt_nxt    = '0;
            end
        endcase
    end

    // output decode: buzzer follows the next state, display muxes alarm vs time
    always_comb begin
        w_buzz_nxt = (w_state_nxt == S_RING);
        if (r_state == S_ALM_HR || r_state == S_ALM_MIN) begin
            DispHr  = r_ahr;
            DispMin = r_amin;
        end else begin
            DispHr  = r_hr;
            DispMin = r_min;
        end
    end

    assign Tick  = r_tick;
    assign Sec   = r_sec;
    assign State = r_state;
    assign Buzz  = r_buzz;

endmodule

// File: tb/tb_alarm_ctrl.sv
`timescale 1ns/1ps
// tb_alarm_ctrl: scoreboard bench for alarm_ctrl. A reference model keeps the
// time as seconds-of-day; each driven cycle pushes the expected outputs and a
// monitor pops and compares them one step after every rising edge.
module tb_alarm_ctrl;
    localparam int TD = 4;
    localparam int RS = 3;
    localparam int SS = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    localparam int RUN = 0, SH = 1, SM = 2, AH = 3, AM = 4, RING = 5, SNOOZE = 6;

    logic       Clk = 1'b0, Rst_n = 1'b1;
    logic       Mode = 1'b0, Inc = 1'b0, Stop = 1'b0, AlarmOn = 1'b0;
    logic       Tick, Buzz;
    logic [4:0] DispHr;
    logic [5:0] DispMin, Sec;
    logic [2:0] State;

    alarm_ctrl #(.TICK_DIV(TD), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Mode(Mode), .Inc(Inc), .Stop(Stop),
        .AlarmOn(AlarmOn), .Tick(Tick), .DispHr(DispHr), .DispMin(DispMin),
        .Sec(Sec), .State(State), .Buzz(Buzz)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_err = 0;

    typedef struct {int tick; int hr; int mn; int sec; int st; int buzz;} exp_t;
    exp_t sb[$];
    exp_t m_e;

    // reference model state
    int m_pc, m_tod, m_ahr, m_amin, m_st, m_rt;
    bit m_tick, m_aonp;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_tick = 0; m_tod = 0; m_ahr = 0; m_amin = 0;
        m_st = RUN; m_rt = 0; m_aonp = 0;
    endtask

    // one clock edge of the specified behaviour
    task automatic m_step(input bit md_raw, input bit in_raw, input bit sp);
        bit en, md, inc, aon;
        int nt, alm, old, h, mi, s;
        en  = m_tick;
        aon = AlarmOn;
        md  = md_raw && !sp;
        inc = in_raw && !sp && !md_raw;
        nt  = (m_tod + 1) % 86400;
        alm = m_ahr * 3600 + m_amin * 60;
        h   = m_tod / 3600;
        mi  = (m_tod / 60) % 60;
        s   = m_tod % 60;
        old = m_st;
        case (old)
            RUN: if (en && aon && nt == alm) begin m_st = RING; m_rt = 0; end
                 else if (md) m_st = SH;
            SH:  if (md) m_st = SM; else if (inc) h = (h + 1) % 24;
            SM:  if (md) m_st = AH; else if (inc) begin mi = (mi + 1) % 60; s = 0; end
            AH:  if (md) m_st = AM; else if (inc) m_ahr = (m_ahr + 1) % 24;
            AM:  if (md) m_st = RUN; else if (inc) m_amin = (m_amin + 1) % 60;
            RING: begin
                if (sp || md_raw || (m_aonp && !aon)) m_st = RUN;
                else if (SNZ && inc) begin m_st = SNOOZE; m_rt = 0; end
                else if (en) begin
                    if (m_rt == RS - 1) m_st = RUN; else m_rt++;
                end
            end
            SNOOZE: begin
                if (sp || md_raw) m_st = RUN;
                else if (en) begin
                    if (m_rt == SS - 1) begin m_st = RING; m_rt = 0; end else m_rt++;
                end
            end
            default: m_st = RUN;
        endcase
        if (old == SH || old == SM) m_tod = h * 3600 + mi * 60 + s;
        else if (en) m_tod = nt;
        m_aonp = aon;
        m_pc   = (m_pc + 1) % TD;
        m_tick = (m_pc == TD - 1);
    endtask

    // drive one cycle of pulses, record the expectation, return just after the edge
    task automatic cycle(input bit md, input bit in, input bit sp);
        exp_t e;
        @(negedge Clk);
        Mode = md; Inc = in; Stop = sp;
        m_step(md, in, sp);
        e.tick = int'(m_tick);
        e.st   = m_st;
        e.buzz = (m_st == RING) ? 1 : 0;
        e.sec  = m_tod % 60;
        if (m_st == AH || m_st == AM) begin
            e.hr = m_ahr; e.mn = m_amin;
        end else begin
            e.hr = m_tod / 3600; e.mn = (m_tod / 60) % 60;
        end
        sb.push_back(e);
        @(posedge Clk);
        #2;
    endtask

    // asynchronous reset: outputs must clear with no clock edge
    task automatic do_reset(input string tag);
        Rst_n = 1'b0; Mode = 0; Inc = 0; Stop = 0; AlarmOn = 0;
        #1;
        chk({tag, "_buzz"}, int'(Buzz), 0);
        chk({tag, "_state"}, int'(State), RUN);
        chk({tag, "_tick"}, int'(Tick), 0);
        chk({tag, "_hr"}, int'(DispHr), 0);
        chk({tag, "_min"}, int'(DispMin), 0);
        chk({tag, "_sec"}, int'(Sec), 0);
        m_reset();
        repeat (2) begin @(posedge Clk); #2; end
        Rst_n = 1'b1;
    endtask

    // alarm at 00:01, armed, run until the model says RING
    task automatic ring_up();
        int k;
        do_reset("rst_ru");
        repeat (4) cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        AlarmOn = 1'b1;
        k = 0;
        while (m_st != RING && k < 400) begin cycle(0, 0, 0); k++; end
        chk("ring_reach_bound", int'(k < 400), 1);
    endtask

    // monitor: compare DUT outputs with the queued expectation after each edge
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                chk("sb_tick", int'(Tick), m_e.tick);
                chk("sb_hr", int'(DispHr), m_e.hr);
                chk("sb_min", int'(DispMin), m_e.mn);
                chk("sb_sec", int'(Sec), m_e.sec);
                chk("sb_state", int'(State), m_e.st);
                chk("sb_buzz", int'(Buzz), m_e.buzz);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #2;
        do_reset("rst_init");

        // prescaler and carry
        repeat (3) cycle(0, 0, 0);
        chk("tick_first", int'(Tick), 1);
        chk("sec_before_tick", int'(Sec), 0);
        repeat (237) cycle(0, 0, 0);
        chk("sec_wrap", int'(Sec), 0);
        chk("min_carry", int'(DispMin), 1);

        // set states: 05:02, time held while setting
        do_reset("rst_set");
        cycle(1, 0, 0);
        repeat (5) cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (2) cycle(0, 1, 0);
        cycle(1, 0, 0);
        chk("set_state_almhr", int'(State), AH);
        chk("set_sec_zero", int'(Sec), 0);
        chk("alm_disp_hr", int'(DispHr), 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("set_back_run", int'(State), RUN);
        chk("set_hr_5", int'(DispHr), 5);
        chk("set_min_2", int'(DispMin), 2);

        // ring and auto-stop after RING_SEC ticks
        ring_up();
        chk("ring_state", int'(State), RING);
        chk("ring_buzz", int'(Buzz), 1);
        chk("ring_min", int'(DispMin), 1);
        chk("ring_sec", int'(Sec), 0);
        repeat (11) cycle(0, 0, 0);
        chk("ring_hold", int'(State), RING);
        cycle(0, 0, 0);
        chk("ring_auto_stop", int'(State), RUN);
        chk("ring_auto_buzz", int'(Buzz), 0);

        // Stop beats Inc
        ring_up();
        cycle(0, 1, 1);
        chk("stop_inc_state", int'(State), RUN);
        chk("stop_inc_buzz", int'(Buzz), 0);

        // Inc alone while ringing
        ring_up();
        cycle(0, 1, 0);
`ifdef ALARM_SNOOZE_EN
        chk("snooze_enter", int'(State), SNOOZE);
        chk("snooze_buzz", int'(Buzz), 0);
        repeat (6) cycle(0, 0, 0);
        chk("snooze_hold", int'(State), SNOOZE);
        cycle(0, 0, 0);
        chk("snooze_rering", int'(State), RING);
        chk("snooze_rering_buzz", int'(Buzz), 1);
`else
        chk("nosnooze_state", int'(State), RING);
        chk("nosnooze_buzz", int'(Buzz), 1);
`endif

        // midnight wrap with the alarm armed at 00:00
        do_reset("rst_wrap");
        AlarmOn = 1'b1;
        cycle(1, 0, 0);
        repeat (23) cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (59) cycle(0, 1, 0);
        repeat (3) cycle(1, 0, 0);
        k = 0;
        while (m_tod != 0 && k < 400) begin cycle(0, 0, 0); k++; end
        chk("wrap_bound", int'(k < 400), 1);
        chk("wrap_hr", int'(DispHr), 0);
        chk("wrap_min", int'(DispMin), 0);
        chk("wrap_sec", int'(Sec), 0);
        chk("wrap_ring", int'(State), RING);
        chk("wrap_buzz_on", int'(Buzz), 1);

        // async reset while ringing
        do_reset("rst_midring");

        // randomized traffic starting from a ringing alarm
        ring_up();
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) AlarmOn = ~AlarmOn;
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0);
        end
        do_reset("rst_rand");
        AlarmOn = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 299) == 0) AlarmOn = ~AlarmOn;
            cycle($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
